// File: rtl/tx_arbiter_sequence_recorder_mp_if.sv
// Bundle between the TX arbiter FSM and the grant sequence recorder.
// The arbiter is the master; the recorder FIFO is the slave.
interface tx_arbiter_sequence_recorder_mp_if #(
  parameter int DATA_WIDTH = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_WR     = 4,
  parameter int NUM_RD     = 2,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int WM_WIDTH   = $clog2(NUM_WR + 1),
  parameter int RM_WIDTH   = $clog2(NUM_RD + 1)
);
  logic                         wr_en;
  logic [WM_WIDTH-1:0]          wr_mode;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
  logic                         rd_en;
  logic [RM_WIDTH-1:0]          rd_mode;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_valid;
  logic [ADDR_WIDTH:0]          available;
  logic [ADDR_WIDTH:0]          count;
  logic                         empty;
  logic                         full;
  logic                         overflow_err;
  logic                         underflow_err;

  modport master (
    output wr_en, wr_mode, wr_data,
    output rd_en, rd_mode,
    input  rd_data, rd_valid,
    input  available, count,
    input  empty, full,
    input  overflow_err, underflow_err
  );

  modport slave (
    input  wr_en, wr_mode, wr_data,
    input  rd_en, rd_mode,
    output rd_data, rd_valid,
    output available, count,
    output empty, full,
    output overflow_err, underflow_err
  );
endinterface

// File: rtl/tx_arbiter_sequence_recorder_mp.sv
// Multi-port in-order FIFO recording TX arbiter grant order.
// Head NUM_RD entries are shown ahead to the arbiter FSM.
module tx_arbiter_sequence_recorder_mp #(
  parameter int DATA_WIDTH = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_WR     = 4,
  parameter int NUM_RD     = 2,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int WM_WIDTH   = $clog2(NUM_WR + 1),
  parameter int RM_WIDTH   = $clog2(NUM_RD + 1)
) (
  input logic clk,
  input logic rst,
  tx_arbiter_sequence_recorder_mp_if.slave bus
);

  typedef logic [ADDR_WIDTH:0]   ptr_t;
  typedef logic [ADDR_WIDTH-1:0] idx_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  ptr_t cnt;
  ptr_t avail;

  logic ovf_q;
  logic unf_q;

  logic [31:0] wm;
  logic [31:0] rm;
  logic [31:0] cnt32;
  logic [31:0] av32;

  logic wr_ok;
  logic rd_ok;

  idx_t wr_idx [NUM_WR];
  idx_t rd_idx [NUM_RD];

  // Pointers carry one extra wrap bit, so the
  // difference is the occupancy even when full.
  assign cnt   = wr_ptr - rd_ptr;
  assign avail = ptr_t'(FIFO_DEPTH) - cnt;

  assign wm    = 32'(bus.wr_mode);
  assign rm    = 32'(bus.rd_mode);
  assign cnt32 = 32'(cnt);
  assign av32  = 32'(avail);

  assign wr_ok = bus.wr_en
              && (wm != 32'd0)
              && (wm <= 32'(NUM_WR))
              && (wm <= av32);

  assign rd_ok = bus.rd_en
              && (rm != 32'd0)
              && (rm <= 32'(NUM_RD))
              && (rm <= cnt32);

  always_comb begin
    ptr_t p;
    p = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      p = wr_ptr + ptr_t'(i);
      wr_idx[i] = p[ADDR_WIDTH-1:0];
    end
  end

  always_comb begin
    ptr_t p;
    p = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      p = rd_ptr + ptr_t'(i);
      rd_idx[i] = p[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (32'(i) < wm) begin
          mem[wr_idx[i]] <=
            bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ptr_t'(bus.wr_mode);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ptr_t'(bus.rd_mode);
      end
      ovf_q <= bus.wr_en && (wm != 32'd0) && !wr_ok;
      unf_q <= bus.rd_en && !rd_ok;
    end
  end

  always_comb begin
    bus.rd_data  = '0;
    bus.rd_valid = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      bus.rd_valid[i] = !rst && (cnt32 > 32'(i));
      if (bus.rd_valid[i]) begin
        bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
          mem[rd_idx[i]];
      end
    end
  end

  assign bus.count         = cnt;
  assign bus.available     = avail;
  assign bus.empty         = (cnt == '0);
  assign bus.full          = (cnt == ptr_t'(FIFO_DEPTH));
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;

endmodule

// File: tb/tb_tx_arbiter_sequence_recorder_mp.sv
// Directed bench for the grant sequence recorder.
// A tag queue scoreboard predicts head data and occupancy.
module tb_tx_arbiter_sequence_recorder_mp;

  localparam int DW    = 3;
  localparam int DEPTH = 16;
  localparam int NW    = 4;
  localparam int NR    = 2;

  logic clk;
  logic rst;

  int checks;
  int failures;

  logic [DW-1:0] sb [$];
  logic exp_ovf;
  logic exp_unf;

  tx_arbiter_sequence_recorder_mp_if #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .NUM_WR(NW), .NUM_RD(NR)
  ) bus ();

  tx_arbiter_sequence_recorder_mp #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .NUM_WR(NW), .NUM_RD(NR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [NW*DW-1:0] pack(
    input int a, input int b,
    input int c, input int d);
    logic [DW-1:0] s0, s1, s2, s3;
    s0 = DW'(a); s1 = DW'(b);
    s2 = DW'(c); s3 = DW'(d);
    return {s3, s2, s1, s0};
  endfunction

  task automatic chk_state();
    int n;
    logic [NR-1:0] ev;
    logic [DW-1:0] ed;
    n = sb.size();
    chk("count", 32'(bus.count), 32'(n));
    chk("available", 32'(bus.available), 32'(DEPTH - n));
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("full", 32'(bus.full), 32'(n == DEPTH));
    chk("overflow_err", 32'(bus.overflow_err), 32'(exp_ovf));
    chk("underflow_err", 32'(bus.underflow_err), 32'(exp_unf));
    ev = '0;
    for (int i = 0; i < NR; i++) begin
      ev[i] = (n > i);
      ed = (n > i) ? sb[i] : '0;
      chk($sformatf("rd_data%0d", i),
          32'(bus.rd_data[i*DW +: DW]), 32'(ed));
    end
    chk("rd_valid", 32'(bus.rd_valid), 32'(ev));
  endtask

  task automatic cyc(input logic r,
                     input logic wen, input int wm,
                     input logic [NW*DW-1:0] wd,
                     input logic ren, input int rm);
    int n;
    logic wacc, racc;
    logic [DW-1:0] tags [NW];
    n = sb.size();
    wacc = wen && wm != 0 && wm <= NW && wm <= DEPTH - n;
    racc = ren && rm != 0 && rm <= NR && rm <= n;
    for (int i = 0; i < NW; i++) tags[i] = wd[i*DW +: DW];
    rst = r;
    bus.wr_en = wen;
    bus.wr_mode = 3'(wm);
    bus.wr_data = wd;
    bus.rd_en = ren;
    bus.rd_mode = 2'(rm);
    @(posedge clk);
    #1;
    if (r) begin
      sb.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      if (racc)
        for (int i = 0; i < rm; i++) void'(sb.pop_front());
      if (wacc)
        for (int i = 0; i < wm; i++) sb.push_back(tags[i]);
      exp_ovf = wen && wm != 0 && !wacc;
      exp_unf = ren && !racc;
    end
    chk_state();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 0, '0, 1'b0, 0);
  endtask

  task automatic wr(input int wm, input logic [NW*DW-1:0] wd);
    cyc(1'b0, 1'b1, wm, wd, 1'b0, 0);
  endtask

  task automatic rd(input int rm);
    cyc(1'b0, 1'b0, 0, '0, 1'b1, rm);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_mode = '0;
    bus.wr_data = '0;
    bus.rd_en = 1'b0;
    bus.rd_mode = '0;

    cyc(1'b1, 1'b0, 0, '0, 1'b0, 0);
    cyc(1'b1, 1'b0, 0, '0, 1'b0, 0);
    idle();

    wr(3, pack(1, 2, 3, 0));
    cyc(1'b0, 1'b1, 0, pack(7, 7, 7, 7), 1'b0, 0);
    wr(4, pack(4, 5, 6, 7));
    wr(4, pack(0, 1, 2, 3));
    wr(3, pack(4, 5, 6, 0));
    wr(4, pack(1, 1, 1, 1));
    idle();
    wr(2, pack(7, 0, 0, 0));
    wr(1, pack(5, 0, 0, 0));

    while (sb.size() > 0) rd(2);
    wr(5, pack(1, 2, 3, 4));
    idle();

    wr(4, pack(1, 2, 3, 4));
    wr(4, pack(5, 6, 7, 0));
    wr(4, pack(1, 3, 5, 7));
    wr(2, pack(2, 4, 0, 0));
    while (sb.size() > 0) rd(2);

    wr(4, pack(4, 5, 6, 7));
    rd(2);
    rd(2);

    wr(1, pack(6, 0, 0, 0));
    cyc(1'b0, 1'b1, 1, pack(2, 0, 0, 0), 1'b1, 2);
    idle();
    rd(1);
    rd(1);

    wr(4, pack(3, 1, 4, 1));
    wr(1, pack(5, 0, 0, 0));
    cyc(1'b1, 1'b1, 4, pack(1, 2, 3, 4), 1'b1, 2);
    idle();
    wr(2, pack(6, 2, 0, 0));
    rd(2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_arbiter_sequence_recorder_mp.md
Name: tx_arbiter_sequence_recorder_mp

Overview:
Parametrised multi-port in-order FIFO that records the sequence in which TLP sources were granted by the TX arbiter. Each cycle it accepts up to NUM_WR source tags and retires up to NUM_RD tags. The head NUM_RD entries are always visible (show-ahead) to the arbiter FSM that drives the downstream packet mux. Successor of the fixed 4-write / 2-read recorder: port counts, width and depth are generalised, and it adds occupancy, full/empty and overflow/underflow error reporting.

Parameters:
DATA_WIDTH, 3, width of one source tag (Tx_Arbiter_Sources_t encoding)
FIFO_DEPTH, 16, number of entries; must be a power of two, at least max(NUM_WR, NUM_RD)
NUM_WR, 4, maximum entries written per cycle
NUM_RD, 2, maximum entries read per cycle
ADDR_WIDTH, $clog2(FIFO_DEPTH), pointer index width (derived)
WM_WIDTH, $clog2(NUM_WR+1), wr_mode width (derived)
RM_WIDTH, $clog2(NUM_RD+1), rd_mode width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_en  in  1  write request
wr_mode  in  WM_WIDTH  number of tags to write (0..NUM_WR)
wr_data  in  NUM_WR*DATA_WIDTH  slot i in bits [i*DATA_WIDTH +: DATA_WIDTH]; slot 0 is oldest
rd_en  in  1  read request
rd_mode  in  RM_WIDTH  number of tags to retire (0..NUM_RD)
rd_data  out  NUM_RD*DATA_WIDTH  head entries; slot 0 = head
rd_valid  out  NUM_RD  rd_valid[i] = 1 when occupancy > i
available  out  ADDR_WIDTH+1  free entries
count  out  ADDR_WIDTH+1  occupied entries
empty  out  1  count == 0
full  out  1  count == FIFO_DEPTH
overflow_err  out  1  one-cycle pulse on a rejected write
underflow_err  out  1  one-cycle pulse on a rejected read

Behaviour:
- Interface: single clock domain, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a clock edge): wr_ptr=0, rd_ptr=0, count=0, available=FIFO_DEPTH, empty=1, full=0, rd_valid=0, overflow_err=0, underflow_err=0. Storage contents are don't-care, but rd_data must be driven all-zero while rst is asserted.
- Reset mid-operation overrides any same-cycle write or read. No error pulse is raised in a reset cycle.
- Pointers are ADDR_WIDTH+1 bits wide and wrap modulo 2*FIFO_DEPTH. Storage index is ptr[ADDR_WIDTH-1:0]. count = wr_ptr - rd_ptr, with no saturation.
- Write: accepted when wr_en=1, wr_mode != 0, wr_mode <= NUM_WR and wr_mode <= available, where available is the registered pre-cycle value. Same-cycle reads do not free space for writes.
  - On accept, slots 0..wr_mode-1 go to wr_ptr+0..wr_mode-1 (wrapping) and wr_ptr += wr_mode.
  - Any other write request with wr_en=1 and wr_mode != 0 is dropped entirely (no partial write), and overflow_err pulses for the next cycle.
  - wr_en=1 with wr_mode=0 is a no-op and raises no error.
- Read: accepted when rd_en=1, rd_mode != 0, rd_mode <= NUM_RD and rd_mode <= count, where count is the pre-cycle value. Same-cycle writes are not readable.
  - On accept, rd_ptr += rd_mode.
  - Any other read request is dropped entirely, and underflow_err pulses for the next cycle.
- Simultaneous accepted read and write: both apply. Next count = count + wr_mode - rd_mode, and available = FIFO_DEPTH - next count.
- rd_data / rd_valid: combinational from storage at rd_ptr+i (wrapping), so data is visible the cycle after the write commits. Slots with rd_valid[i]=0 drive zero.
- Latency: write-to-visible is 1 cycle. count, available, full and empty are registered and update the cycle after the edge.
- Ordering: strict FIFO across wrap-around, including multi-entry writes and reads that straddle index FIFO_DEPTH-1 to 0.
- No combinational path from wr_* or rd_* inputs to any output.

Test Plan:
- Reset then idle (defaults) -> available=16, count=0, empty=1, rd_valid=00, rd_data=0.
- Write wr_mode=3, tags {1,2,3} -> next cycle: count=3, available=13, rd_data slot0=1, slot1=2, rd_valid=11.
- Fill to 14 entries, then request wr_mode=4 -> write dropped, overflow_err=1 for exactly one cycle, count stays 14. Then wr_mode=2 -> full=1, available=0.
- Advance pointers to wr_ptr=14, then write 4 tags {4,5,6,7} and read 2 per cycle until empty -> tags emerge in order across the index 15 to 0 wrap.
- count=1, request rd_mode=2 -> read dropped, underflow_err pulses once, count stays 1. Same cycle with wr_mode=1 -> write still accepted, count becomes 2.
- count=5, simultaneous wr_mode=4 and rd_mode=2 with rst=1 -> next cycle: all outputs at reset values, no error pulses.
